// File: rtl/tb_clk_gen_pkg.sv
// tb_clk_gen_pkg: shared types and helpers for the derived-clock generator.
//   state_t     : generator phase (IDLE, HIGH, LOW)
//   MIN_PERIOD  : smallest legal period in reference cycles
//   basic_high  : high time of a "basic" clock, floor(p/2)
package tb_clk_gen_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam int MIN_PERIOD = 2;

  function automatic logic [31:0] basic_high(input logic [31:0] p);
    return p >> 1;
  endfunction

endpackage

// File: rtl/tb_clk_gen_if.sv
// tb_clk_gen_if: control/config and generated-clock signals of tb_clk_gen.
//   master : drives enable and cfg_*, observes clk/clk_rise/clk_fall/running/cfg_err
//   slave  : the generator side
// With TB_CLK_GEN_CNT_EN defined the bundle also carries edge_count[31:0].
interface tb_clk_gen_if #(parameter int CNT_W = 16);
  logic             enable;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_basic;
  logic             clk;
  logic             clk_rise;
  logic             clk_fall;
  logic             running;
  logic             cfg_err;
`ifdef TB_CLK_GEN_CNT_EN
  logic [31:0]      edge_count;

  modport master (output enable, cfg_valid, cfg_period, cfg_high, cfg_basic,
                  input  clk, clk_rise, clk_fall, running, cfg_err, edge_count);
  modport slave  (input  enable, cfg_valid, cfg_period, cfg_high, cfg_basic,
                  output clk, clk_rise, clk_fall, running, cfg_err, edge_count);
`else
  modport master (output enable, cfg_valid, cfg_period, cfg_high, cfg_basic,
                  input  clk, clk_rise, clk_fall, running, cfg_err);
  modport slave  (input  enable, cfg_valid, cfg_period, cfg_high, cfg_basic,
                  output clk, clk_rise, clk_fall, running, cfg_err);
`endif
endinterface

// File: rtl/tb_clk_gen_cfg.sv
// tb_clk_gen_cfg: combinational config check.
//   period, high, basic : requested configuration
//   ok                  : period >= MIN_PERIOD and 1 <= eff_high <= period-1
//   eff_high            : high time actually used (floor(period/2) in basic mode)
module tb_clk_gen_cfg
  import tb_clk_gen_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high,
  input  logic             basic,
  output logic             ok,
  output logic [CNT_W-1:0] eff_high
);

  always_comb begin
    eff_high = basic ? CNT_W'(basic_high(32'(period))) : high;
    ok       = (32'(period) >= 32'(MIN_PERIOD)) && (eff_high != '0) && (eff_high < period);
  end

endmodule

// File: rtl/tb_clk_gen.sv
// tb_clk_gen: synthesizable programmable derived-clock generator.
//   clock : reference clock (rising edge)
//   reset : asynchronous, active-low
//   bus   : tb_clk_gen_if slave -- enable, cfg_* in; clk, clk_rise, clk_fall,
//           running, cfg_err (and edge_count) out
// Optional feature: define TB_CLK_GEN_CNT_EN for a 32-bit clk rising-edge counter.
// A config accepted while running is staged and only takes effect at the start
// of the next period, so no period ever mixes old and new parameters.
module tb_clk_gen
  import tb_clk_gen_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 2
) (
  input  logic        clock,
  input  logic        reset,
  tb_clk_gen_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d, high_q, high_d;
  logic [CNT_W-1:0] pend_per, pend_per_d, pend_high, pend_high_d;
  logic             pend_v, pend_v_d;
  logic             err_q, err_d;
  logic             clk_q, rise_q, fall_q;
  logic             ok;
  logic [CNT_W-1:0] eff_high;
  logic             start;
  logic [CNT_W-1:0] st_per, st_high;

  tb_clk_gen_cfg #(.CNT_W(CNT_W)) u_cfg (
    .period   (bus.cfg_period),
    .high     (bus.cfg_high),
    .basic    (bus.cfg_basic),
    .ok       (ok),
    .eff_high (eff_high)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      per_q     <= CNT_W'(DEFAULT_PERIOD);
      high_q    <= CNT_W'(DEFAULT_PERIOD / 2);
      pend_per  <= '0;
      pend_high <= '0;
      pend_v    <= 1'b0;
      err_q     <= 1'b0;
      clk_q     <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      high_q    <= high_d;
      pend_per  <= pend_per_d;
      pend_high <= pend_high_d;
      pend_v    <= pend_v_d;
      err_q     <= err_d;
      clk_q     <= (state_d == HIGH);
      rise_q    <= (state_d == HIGH) && (state_q != HIGH);
      fall_q    <= (state_d != HIGH) && (state_q == HIGH);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    per_d       = per_q;
    high_d      = high_q;
    pend_per_d  = pend_per;
    pend_high_d = pend_high;
    pend_v_d    = pend_v;
    err_d       = err_q;
    start       = 1'b0;

    // Parameters for a period starting this edge: a config arriving on the
    // boundary wins over a staged one, which wins over the active one.
    if (bus.cfg_valid && ok) begin
      st_per  = bus.cfg_period;
      st_high = eff_high;
    end else if (pend_v) begin
      st_per  = pend_per;
      st_high = pend_high;
    end else begin
      st_per  = per_q;
      st_high = high_q;
    end

    if (bus.cfg_valid) begin
      err_d = !ok;
      if (ok) begin
        if (state_q == IDLE) begin
          per_d    = bus.cfg_period;
          high_d   = eff_high;
          pend_v_d = 1'b0;
        end else begin
          pend_per_d  = bus.cfg_period;
          pend_high_d = eff_high;
          pend_v_d    = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: start = bus.enable;
      HIGH: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = LOW;
          cnt_d   = per_q - high_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt_q == CNT_W'(1)) begin
          if (bus.enable) start = 1'b1;
          else            state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d  = HIGH;
      cnt_d    = st_high;
      per_d    = st_per;
      high_d   = st_high;
      pend_v_d = 1'b0;
    end
  end

  assign bus.clk      = clk_q;
  assign bus.clk_rise = rise_q;
  assign bus.clk_fall = fall_q;
  assign bus.running  = (state_q != IDLE);
  assign bus.cfg_err  = err_q;

`ifdef TB_CLK_GEN_CNT_EN
  logic [31:0] edge_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      edge_cnt <= '0;
    else if ((state_d == HIGH) && (state_q != HIGH))
      edge_cnt <= edge_cnt + 32'd1;
  end

  assign bus.edge_count = edge_cnt;
`endif

endmodule

// File: tb/tb_tb_clk_gen.sv
// tb_tb_clk_gen: randomized + directed bench for tb_clk_gen. A reference model
// tracks the position inside the current period (clk = pos < high) and is
// compared against the DUT every reference cycle.
module tb_tb_clk_gen;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [CNT_W-1:0] cfg_high = '0;
  logic             cfg_basic = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_run;
  int          m_pos, m_per, m_high;
  bit          m_pend_v;
  int          m_pend_per, m_pend_high;
  bit          m_err;
  bit          e_clk, e_rise, e_fall;
  logic [31:0] m_edges;

  tb_clk_gen_if #(.CNT_W(CNT_W)) bus ();

  assign bus.enable     = enable;
  assign bus.cfg_valid  = cfg_valid;
  assign bus.cfg_period = cfg_period;
  assign bus.cfg_high   = cfg_high;
  assign bus.cfg_basic  = cfg_basic;

  tb_clk_gen #(.CNT_W(CNT_W), .DEFAULT_PERIOD(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_per = 2; m_high = 1;
    m_pend_v = 0; m_pend_per = 0; m_pend_high = 0;
    m_err = 0; e_clk = 0; e_rise = 0; e_fall = 0; m_edges = '0;
  endtask

  // One reference edge, using the inputs currently applied.
  task automatic model_step();
    int  p, h;
    bit  ok, last, start, prev;
    p    = int'(cfg_period);
    h    = cfg_basic ? p / 2 : int'(cfg_high);
    ok   = cfg_valid && (p >= 2) && (h >= 1) && (h <= p - 1);
    prev = e_clk;
    if (cfg_valid) m_err = !ok;
    last  = m_run && (m_pos == m_per - 1);
    start = (!m_run || last) && enable;
    if (start) begin
      if (ok) begin
        m_per = p; m_high = h;
      end else if (m_pend_v) begin
        m_per = m_pend_per; m_high = m_pend_high;
      end
      m_pend_v = 0; m_run = 1; m_pos = 0;
    end else begin
      if (ok) begin
        if (m_run) begin
          m_pend_per = p; m_pend_high = h; m_pend_v = 1;
        end else begin
          m_per = p; m_high = h; m_pend_v = 0;
        end
      end
      if (m_run) begin
        if (last) m_run = 0;
        else      m_pos++;
      end
    end
    e_clk  = m_run && (m_pos < m_high);
    e_rise = e_clk && !prev;
    e_fall = !e_clk && prev;
    if (e_rise) m_edges = m_edges + 32'd1;
  endtask

  task automatic check_outputs();
    chk("clk",      32'(bus.clk),      32'(e_clk));
    chk("clk_rise", 32'(bus.clk_rise), 32'(e_rise));
    chk("clk_fall", 32'(bus.clk_fall), 32'(e_fall));
    chk("running",  32'(bus.running),  32'(m_run));
    chk("cfg_err",  32'(bus.cfg_err),  32'(m_err));
`ifdef TB_CLK_GEN_CNT_EN
    chk("edge_count", bus.edge_count, m_edges);
`endif
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_step();
      #1;
      check_outputs();
    end
  endtask

  task automatic cfg(input int p, input int h, input bit basic);
    cfg_period = CNT_W'(p);
    cfg_high   = CNT_W'(h);
    cfg_basic  = basic;
    cfg_valid  = 1'b1;
    step(1);
    cfg_valid  = 1'b0;
  endtask

  // advance until the model sits at position pos of a period of length per
  task automatic step_until(input int per, input int pos, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (m_run && m_per == per && m_pos == pos) hit = 1;
      else step(1);
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs();
    reset = 1'b1;
    #2;

    // defaults: 1 high, 1 low
    enable = 1'b1;
    step(8);

    // stop, then basic P=10 from IDLE
    enable = 1'b0;
    step(4);
    cfg(10, 0, 1'b1);
    enable = 1'b1;
    step(25);

    // P=5 basic staged while running, then a rejected P=1
    cfg(5, 0, 1'b1);
    step(15);
    cfg(1, 0, 1'b1);
    chk("err_sticky", 32'(bus.cfg_err), 32'd1);
    step(10);

    // mid-HIGH reconfig of a P=10 period to P=4, high=1
    cfg(10, 0, 1'b1);
    step_until(10, 2, "wait_p10_high");
    cfg(4, 1, 1'b0);
    chk("err_cleared", 32'(bus.cfg_err), 32'd0);
    step(20);

    // drop enable during HIGH of P=8
    cfg(8, 0, 1'b1);
    step_until(8, 1, "wait_p8_high");
    enable = 1'b0;
    step(12);
    chk("stopped_low", 32'(bus.clk), 32'd0);
    enable = 1'b1;
    step(1);
    chk("restart_rise", 32'(bus.clk_rise), 32'd1);
    step(10);

    // asynchronous reset in the middle of HIGH
    cfg(6, 3, 1'b0);
    step_until(6, 1, "wait_p6_high");
    cfg_period = 16'd9; cfg_basic = 1'b1; cfg_valid = 1'b1;  // staged, then lost
    step(1);
    cfg_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_clk", 32'(bus.clk), 32'd0);
    check_outputs();
    #3;
    reset = 1'b1;
    step(10);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 9) != 0);
      cfg_valid  = ($urandom_range(0, 19) == 0);
      cfg_period = CNT_W'($urandom_range(0, 12));
      cfg_high   = CNT_W'($urandom_range(0, 13));
      cfg_basic  = 1'($urandom_range(0, 1));
      step(1);
    end
    cfg_valid = 1'b0;
    enable    = 1'b0;
    step(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
